// File: rtl/axis_oled_text_writer.sv
// Purpose: AXI4-Stream ASCII sink that builds four 16-char OLED rows in a shadow buffer and commits them atomically on tlast.
// Latency: tlast beat accepted at edge N -> str1..str4 and frame_done visible after edge N+1 (after edge N+5 for FF+tlast).
// Backpressure: tready is a registered copy of "next state is RECV", so it drops for the COMMIT/CLEAR cycles; optional macro OLED_TXT_AUTOCLEAR_EN blanks the shadow after every commit.
module axis_oled_text_writer #(
  parameter int         ROW_CHARS = 16,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_axis_tdata,
  input  logic         s_axis_tvalid,
  input  logic         s_axis_tlast,
  output logic         s_axis_tready,
  output logic [127:0] str1,
  output logic [127:0] str2,
  output logic [127:0] str3,
  output logic [127:0] str4,
  output logic [1:0]   cursor_row,
  output logic [3:0]   cursor_col,
  output logic         frame_done,
  output logic         overflow
);

  localparam logic [3:0]   LAST_COL  = 4'(ROW_CHARS - 1);
  localparam logic [1:0]   LAST_ROW  = 2'd3;
  localparam logic [127:0] BLANK_ROW = {ROW_CHARS{FILL_CHAR}};

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    ST_RECV   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0][127:0]   shadow_q, shadow_d;
  logic [3:0][127:0]   str_q, str_d;
  logic [1:0]          row_q, row_d;
  logic [3:0]          col_q, col_d;
  logic [1:0]          clr_row_q, clr_row_d;
  logic                full_q, full_d;
  logic                ovf_q, ovf_d;
  logic                pend_q, pend_d;
  logic                frame_done_q, frame_done_d;
  logic                tready_q;

  logic                beat;
  logic                printable;
  logic [6:0]          wr_lsb;

  assign beat      = s_axis_tvalid && tready_q;
  assign printable = (s_axis_tdata >= 8'h20) && (s_axis_tdata <= 8'h7E);
  // Column 0 lives in the top byte, so the byte offset is (15 - col) = ~col.
  assign wr_lsb    = {~col_q, 3'b000};

  // Next-state, shadow writes, cursor movement and commit in one decode.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    str_d        = str_q;
    row_d        = row_q;
    col_d        = col_q;
    clr_row_d    = clr_row_q;
    full_d       = full_q;
    ovf_d        = ovf_q;
    pend_d       = pend_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_RECV: begin
        if (beat) begin
          if (printable) begin
            if (full_q) begin
              ovf_d = 1'b1;
            end else begin
              shadow_d[row_q][wr_lsb +: 8] = s_axis_tdata;
              if (col_q != LAST_COL) begin
                col_d = col_q + 4'd1;
              end else if (row_q != LAST_ROW) begin
                col_d = 4'd0;
                row_d = row_q + 2'd1;
              end else begin
                // Last cell written: park the cursor and refuse further text.
                full_d = 1'b1;
              end
            end
          end else begin
            case (s_axis_tdata)
              CH_LF: begin
                col_d = 4'd0;
                if (row_q != LAST_ROW) row_d = row_q + 2'd1;
                else                   full_d = 1'b1;
              end
              CH_CR: col_d = 4'd0;
              CH_BS: begin
                if (col_q != 4'd0) col_d = col_q - 4'd1;
                full_d = 1'b0;
              end
              default: ;
            endcase
          end

          // A form feed wins over tlast; the commit is deferred until the clear finishes.
          if (s_axis_tdata == CH_FF) begin
            state_d   = ST_CLEAR;
            clr_row_d = 2'd0;
            pend_d    = s_axis_tlast;
          end else if (s_axis_tlast) begin
            state_d = ST_COMMIT;
          end
        end
      end

      ST_CLEAR: begin
        shadow_d[clr_row_q] = BLANK_ROW;
        clr_row_d           = clr_row_q + 2'd1;
        row_d               = 2'd0;
        col_d               = 4'd0;
        full_d              = 1'b0;
        if (clr_row_q == LAST_ROW) begin
          state_d = pend_q ? ST_COMMIT : ST_RECV;
          pend_d  = 1'b0;
        end
      end

      ST_COMMIT: begin
        str_d        = shadow_q;
        frame_done_d = 1'b1;
        row_d        = 2'd0;
        col_d        = 4'd0;
        full_d       = 1'b0;
        ovf_d        = 1'b0;
`ifdef OLED_TXT_AUTOCLEAR_EN
        state_d      = ST_CLEAR;
        clr_row_d    = 2'd0;
`else
        state_d      = ST_RECV;
`endif
      end

      default: state_d = ST_RECV;
    endcase
  end

  // State, buffers and flags; tready follows the next state so it never depends on tvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RECV;
      shadow_q     <= {4{BLANK_ROW}};
      str_q        <= {4{BLANK_ROW}};
      row_q        <= 2'd0;
      col_q        <= 4'd0;
      clr_row_q    <= 2'd0;
      full_q       <= 1'b0;
      ovf_q        <= 1'b0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tready_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      str_q        <= str_d;
      row_q        <= row_d;
      col_q        <= col_d;
      clr_row_q    <= clr_row_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
      tready_q     <= (state_d == ST_RECV);
    end
  end

  assign s_axis_tready = tready_q;
  assign str1          = str_q[0];
  assign str2          = str_q[1];
  assign str3          = str_q[2];
  assign str4          = str_q[3];
  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign frame_done    = frame_done_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_axis_oled_text_writer.sv
// Bench for axis_oled_text_writer: table of single frames with hand-derived screens,
// hand sequences for overflow, form feed, mid-frame reset, then random frames vs a screen model.
module tb_axis_oled_text_writer;

`ifdef OLED_TXT_AUTOCLEAR_EN
  localparam int AC   = 4;
  localparam bit AUTO = 1'b1;
`else
  localparam int AC   = 0;
  localparam bit AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   tdata = 8'h00;
  logic         tvalid = 1'b0;
  logic         tlast = 1'b0;
  logic         tready;
  logic [127:0] str1, str2, str3, str4;
  logic [1:0]   cursor_row;
  logic [3:0]   cursor_col;
  logic         frame_done;
  logic         overflow;

  axis_oled_text_writer dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .str1(str1), .str2(str2), .str3(str3), .str4(str4),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [127:0] pad16(input string s);
    logic [127:0] v = {16{8'h20}};
    for (int i = 0; i < s.len() && i < 16; i++) v[127 - 8*i -: 8] = s[i];
    return v;
  endfunction

  // ---------------- screen model: characters in a 4x16 grid ----------------
  logic [7:0]   scr [4][16];
  int           mr, mc;
  bit           mfull;
  logic [511:0] exp_q[$];

  function automatic void m_clear();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 16; c++) scr[r][c] = 8'h20;
    mr = 0; mc = 0; mfull = 0;
  endfunction

  function automatic void m_reset();
    m_clear();
    exp_q.delete();
  endfunction

  function automatic logic [511:0] m_image();
    logic [511:0] v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++) v[511 - 128*r - 8*c -: 8] = scr[r][c];
    return v;
  endfunction

  function automatic void m_beat(input logic [7:0] b, input bit last);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (!mfull) begin
        scr[mr][mc] = b;
        if (mc < 15) mc++;
        else if (mr < 3) begin mr++; mc = 0; end
        else mfull = 1;
      end
    end else if (b == 8'h0A) begin
      mc = 0;
      if (mr < 3) mr++; else mfull = 1;
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h08) begin
      if (mc > 0) mc--;
      mfull = 0;
    end else if (b == 8'h0C) begin
      m_clear();
    end
    if (last) begin
      exp_q.push_back(m_image());
      mr = 0; mc = 0; mfull = 0;
      if (AUTO) m_clear();
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [7:0] b, input bit last, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    tvalid = 1'b1; tdata = b; tlast = last;
    while (!tready && n < 40) begin @(negedge clk); n++; end
    if (!tready) begin
      chki("send tready timeout", int'(tready), 1);
      tvalid = 1'b0; tlast = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0; tdata = 8'h00;
    m_beat(b, last);
  endtask

  task automatic send_str(input string s, input bit last);
    for (int i = 0; i < s.len(); i++) send(s[i], last && (i == s.len() - 1), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0;
    m_reset();
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  // Call right after the tlast beat was accepted.
  task automatic wait_commit(input string name, input int exp_low);
    int low = 0, fd = 0;
    bit done = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (frame_done) fd++;
      if (tready) done = 1; else low++;
    end
    chki({name, " tready returns"}, int'(done), 1);
    chki({name, " tready low cycles"}, low, exp_low);
    chki({name, " frame_done pulses"}, fd, 1);
    chki({name, " cursor home"}, int'({cursor_row, cursor_col}), 0);
    chki({name, " overflow clear"}, int'(overflow), 0);
    @(negedge clk);
    chki({name, " frame_done one cycle"}, int'(frame_done), 0);
  endtask

  // ---------------- scoreboard and stability monitor ----------------
  logic [511:0] cur;
  logic [511:0] prev_str;
  bit           prev_ok = 0;
  assign cur = {str1, str2, str3, str4};

  always @(negedge clk) begin
    if (frame_done) begin
      chki("sb expected frame pending", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("sb rows", cur, exp_q.pop_front());
    end else if (prev_ok && !rst) begin
      chk("str stable between commits", cur, prev_str);
    end
    prev_str = cur;
    prev_ok  = !rst;
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit    do_rst;
    string txt;
    string r1, r2, r3, r4;
    int    low;
  } vec_t;

  vec_t tv[9];

  function automatic void set_vec(input int i, input bit d, input string t,
                                  input string a, input string b, input string c,
                                  input string e, input int low);
    tv[i].do_rst = d; tv[i].txt = t;
    tv[i].r1 = a; tv[i].r2 = b; tv[i].r3 = c; tv[i].r4 = e;
    tv[i].low = low;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 1, "HELLO",                "HELLO", "", "", "", 1 + AC);
    set_vec(1, 1, "AB\012C\015D",         "AB", "D", "", "", 1 + AC);
    set_vec(2, 0, "XY",                   "XY", AUTO ? "" : "D", "", "", 1 + AC);
    set_vec(3, 0, "Q\010\010RS",          "RS", AUTO ? "" : "D", "", "", 1 + AC);
    set_vec(4, 0, "\014",                 "", "", "", "", 5 + AC);
    set_vec(5, 1, "\012\012\012\012Z",    "", "", "", "", 1 + AC);
    set_vec(6, 1, "ab\007cd",             "abcd", "", "", "", 1 + AC);
    set_vec(7, 1, "0123456789ABCDEFgh",   "0123456789ABCDEF", "gh", "", "", 1 + AC);
    set_vec(8, 0, "\012\012W",            AUTO ? "" : "0123456789ABCDEF",
                                          AUTO ? "" : "gh", "W", "", 1 + AC);

    // Reset state
    m_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset rows blank", cur, {64{8'h20}});
    chki("reset tready", int'(tready), 0);
    chki("reset frame_done", int'(frame_done), 0);
    chki("reset overflow", int'(overflow), 0);
    chki("reset cursor", int'({cursor_row, cursor_col}), 0);
    repeat (3) @(negedge clk);
    chki("tready low while in reset", int'(tready), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chki("tready after reset release", int'(tready), 1);

    // Table-driven frames
    foreach (tv[i]) begin
      if (tv[i].do_rst) do_reset();
      send_str(tv[i].txt, 1);
      wait_commit($sformatf("v%0d", i), tv[i].low);
      chk($sformatf("v%0d rows", i), cur,
          {pad16(tv[i].r1), pad16(tv[i].r2), pad16(tv[i].r3), pad16(tv[i].r4)});
    end

    // 64 printable bytes fill the screen, the next one overflows
    do_reset();
    for (int i = 0; i < 64; i++) send(8'h41, 0, 0);
    chki("full cursor parked", int'({cursor_row, cursor_col}), int'({2'd3, 4'd15}));
    chki("no overflow at exactly full", int'(overflow), 0);
    send(8'h42, 1, 0);
    chki("overflow after dropped byte", int'(overflow), 1);
    chki("tready low in commit", int'(tready), 0);
    wait_commit("overflow frame", 1 + AC);
    chk("overflow rows all A", cur, {64{8'h41}});

    // Form feed with tlast over a full screen
    send(8'h0C, 1, 0);
    wait_commit("ff frame", 5 + AC);
    chk("ff rows blank", cur, {64{8'h20}});

    // Reset in the middle of a frame
    do_reset();
    send_str("HELLO", 1);
    wait_commit("pre-reset frame", 1 + AC);
    send_str("JU", 0);
    @(negedge clk);
    tvalid = 1'b1; tdata = 8'h4B;
    #2 rst = 1'b1;
    #1;
    chk("mid reset rows blank", cur, {64{8'h20}});
    chki("mid reset tready", int'(tready), 0);
    chki("mid reset cursor", int'({cursor_row, cursor_col}), 0);
    tvalid = 1'b0;
    m_reset();
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;
    send_str("OK", 1);
    wait_commit("post-reset frame", 1 + AC);
    chk("post-reset rows", cur, {pad16("OK"), {48{8'h20}}});

    // Random frames, back-to-back with idle gaps, checked by the scoreboard
    do_reset();
    for (int f = 0; f < 14; f++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 30);
      for (int k = 0; k < len; k++) begin
        int r;
        int gap;
        logic [7:0] b;
        r = $urandom_range(0, 99);
        if      (r < 70) b = 8'($urandom_range(32, 126));
        else if (r < 78) b = 8'h0A;
        else if (r < 84) b = 8'h0D;
        else if (r < 90) b = 8'h08;
        else if (r < 92) b = 8'h0C;
        else             b = 8'($urandom_range(0, 255));
        gap = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
        send(b, k == len - 1, gap);
      end
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chki("sb all frames committed", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
